// File: rtl/prog_loader.sv
// ---------------------------------------------------------------------------
// prog_loader
//
// Boot-time program loader placed in front of the instruction memory. It
// takes a byte stream from the host link and assembles little-endian 32-bit
// words. Each finished word is written to instruction memory with a one-cycle
// load_en strobe. The core is held in reset (cpu_rst=1) until the image is
// complete. The image is complete when WORDS words have been written, or
// earlier if the memory raises load_done.
//
// Ports
//   clk         in   system clock, rising edge
//   rst         in   asynchronous active-high reset
//   start       in   begin a load (honoured in IDLE and DONE only)
//   byte_valid  in   host byte present
//   byte_data   in   host byte
//   byte_ready  out  loader consumes byte_data this cycle if byte_valid=1
//   load_done   in   instruction memory reports the image is complete
//   load_en     out  one-cycle write strobe to instruction memory
//   load_inst   out  assembled word, valid while load_en=1, held afterwards
//   cpu_rst     out  core reset hold, low only in DONE
//   busy        out  high in COLLECT and WRITE
//   done        out  high in DONE
//   error       out  sticky inter-byte timeout flag, cleared by start
//   word_count  out  words written in the current load (saturating)
//
// Every output is a flop. Each one is loaded from the next-state value, so
// no input reaches an output in the same cycle.
// ---------------------------------------------------------------------------
module prog_loader #(
    parameter  int WORDS   = 256,
    parameter  int TIMEOUT = 1024,
    localparam int CW      = $clog2(WORDS + 1),
    localparam int TW      = $clog2(TIMEOUT + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          byte_valid,
    input  logic [7:0]    byte_data,
    output logic          byte_ready,
    input  logic          load_done,
    output logic          load_en,
    output logic [31:0]   load_inst,
    output logic          cpu_rst,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [CW-1:0] word_count
);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        WRITE,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      idx_q;      // next byte lane of the word being assembled
    logic [23:0]     asm_q;      // bytes 0..2; byte 3 goes straight to load_inst
    logic [TW-1:0]   to_cnt_q;   // idle cycles since the last accepted byte

    logic            accept;
    logic            start_clear;
    logic            timeout_hit;
    logic [CW-1:0]   count_inc;

    // NOTE: every signal written here gets a default value first. Without
    // that, a path through the case that skips an assignment would infer
    // a latch.
    always_comb begin
        state_d     = state_q;
        accept      = byte_ready && byte_valid;
        start_clear = start && (state_q == IDLE || state_q == DONE);
        // load_done takes priority over the timeout abort.
        timeout_hit = (state_q == COLLECT) && (idx_q != 2'd0) && !accept &&
                      !load_done && (to_cnt_q == TW'(TIMEOUT - 1));
        count_inc   = (word_count < CW'(WORDS)) ? word_count + CW'(1) : word_count;

        case (state_q)
            IDLE: begin
                if (start) state_d = COLLECT;
            end
            COLLECT: begin
                if (load_done)                        state_d = DONE;
                else if (timeout_hit)                 state_d = IDLE;
                else if (accept && idx_q == 2'd3)     state_d = WRITE;
            end
            WRITE: begin
                if (load_done || count_inc == CW'(WORDS)) state_d = DONE;
                else                                      state_d = COLLECT;
            end
            DONE: begin
                if (start) state_d = COLLECT;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only. All flops
    // then sample the values from before the edge, whatever the order of
    // the statements.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= 2'd0;
            asm_q      <= '0;
            to_cnt_q   <= '0;
            byte_ready <= 1'b0;
            load_en    <= 1'b0;
            load_inst  <= '0;
            cpu_rst    <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            word_count <= '0;
        end else begin
            state_q    <= state_d;

            // Outputs decoded from the next state, so they line up with state_q.
            byte_ready <= (state_d == COLLECT);
            load_en    <= (state_d == WRITE);
            busy       <= (state_d == COLLECT) || (state_d == WRITE);
            done       <= (state_d == DONE);
            cpu_rst    <= (state_d != DONE);

            case (state_q)
                IDLE, DONE: begin
                    if (start_clear) begin
                        word_count <= '0;
                        idx_q      <= 2'd0;
                        to_cnt_q   <= '0;
                        error      <= 1'b0;
                    end
                end
                COLLECT: begin
                    if (load_done || timeout_hit) begin
                        // Discard any partial word.
                        idx_q    <= 2'd0;
                        to_cnt_q <= '0;
                        if (timeout_hit) error <= 1'b1;
                    end else if (accept) begin
                        to_cnt_q <= '0;
                        idx_q    <= idx_q + 2'd1;
                        case (idx_q)
                            2'd0:    asm_q[7:0]   <= byte_data;
                            2'd1:    asm_q[15:8]  <= byte_data;
                            2'd2:    asm_q[23:16] <= byte_data;
                            default: load_inst    <= {byte_data, asm_q};
                        endcase
                    end else if (idx_q != 2'd0) begin
                        to_cnt_q <= to_cnt_q + TW'(1);
                    end
                end
                WRITE: begin
                    word_count <= count_inc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// ---------------------------------------------------------------------------
// tb_prog_loader
//
// Directed bench for prog_loader with the default parameters. Inputs change
// and outputs are sampled 1 time unit after each falling clock edge. A
// monitor on the falling edge records every load_en strobe and its load_inst.
// ---------------------------------------------------------------------------
module tb_prog_loader;

    localparam int WORDS   = 256;
    localparam int TIMEOUT = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        load_done;
    logic        load_en;
    logic [31:0] load_inst;
    logic        cpu_rst;
    logic        busy;
    logic        done;
    logic        error;
    logic [8:0]  word_count;

    int n_cmp = 0;
    int n_bad = 0;
    int en_count = 0;
    logic [31:0] got[$];

    prog_loader #(.WORDS(WORDS), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .load_done  (load_done),
        .load_en    (load_en),
        .load_inst  (load_inst),
        .cpu_rst    (cpu_rst),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (load_en === 1'b1) begin
            got.push_back(load_inst);
            en_count++;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Offers one byte and waits until it has been consumed. With gaps=1 the
    // byte is offered on random cycles only.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        bit cons = 1'b0;
        for (int g = 0; g < 200 && !cons; g++) begin
            byte_data  = b;
            byte_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            cons       = byte_valid && byte_ready;
            step();
        end
        if (!cons) begin
            n_cmp++; n_bad++;
            $display("FAIL send_byte: byte %02h not accepted within 200 cycles", b);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gaps);
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    function automatic logic [7:0] img_byte(input int k);
        return 8'((k * 37 + (k >> 2)) & 255);
    endfunction

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00; load_done = 1'b0;
        step(); step();
        n_cmp++; if (load_en !== 1'b0)    begin n_bad++; $display("FAIL reset load_en: got %0b want 0", load_en); end
        n_cmp++; if (load_inst !== 32'h0) begin n_bad++; $display("FAIL reset load_inst: got %08h want 0", load_inst); end
        n_cmp++; if (byte_ready !== 1'b0) begin n_bad++; $display("FAIL reset byte_ready: got %0b want 0", byte_ready); end
        n_cmp++; if (cpu_rst !== 1'b1)    begin n_bad++; $display("FAIL reset cpu_rst: got %0b want 1", cpu_rst); end
        n_cmp++; if (busy !== 1'b0)       begin n_bad++; $display("FAIL reset busy: got %0b want 0", busy); end
        n_cmp++; if (done !== 1'b0)       begin n_bad++; $display("FAIL reset done: got %0b want 0", done); end
        n_cmp++; if (error !== 1'b0)      begin n_bad++; $display("FAIL reset error: got %0b want 0", error); end
        n_cmp++; if (word_count !== 9'd0) begin n_bad++; $display("FAIL reset word_count: got %0d want 0", word_count); end
        rst = 1'b0;
        step(); step();
        n_cmp++; if (busy !== 1'b0 || byte_ready !== 1'b0) begin
            n_bad++; $display("FAIL idle_hold busy/byte_ready: got %0b/%0b want 0/0", busy, byte_ready);
        end
    endtask

    task automatic test_first_word();
        int base = en_count;
        logic [7:0] bytes [4] = '{8'h13, 8'h00, 8'h00, 8'h00};
        do_start();
        // Cycle S+1: collecting.
        n_cmp++; if (byte_ready !== 1'b1 || busy !== 1'b1) begin
            n_bad++; $display("FAIL first_collect byte_ready/busy: got %0b/%0b want 1/1", byte_ready, busy);
        end
        for (int i = 0; i < 4; i++) begin
            byte_valid = 1'b1; byte_data = bytes[i];
            step();
        end
        byte_valid = 1'b0;
        // Cycle S+5: write strobe.
        n_cmp++; if (load_en !== 1'b1 || load_inst !== 32'h00000013) begin
            n_bad++; $display("FAIL first_write load_en/load_inst: got %0b/%08h want 1/00000013", load_en, load_inst);
        end
        n_cmp++; if (byte_ready !== 1'b0) begin n_bad++; $display("FAIL first_write byte_ready: got %0b want 0", byte_ready); end
        step();
        // Cycle S+6: back to collecting, count updated, word held.
        n_cmp++; if (load_en !== 1'b0 || byte_ready !== 1'b1) begin
            n_bad++; $display("FAIL first_after load_en/byte_ready: got %0b/%0b want 0/1", load_en, byte_ready);
        end
        n_cmp++; if (word_count !== 9'd1) begin n_bad++; $display("FAIL first_count word_count: got %0d want 1", word_count); end
        n_cmp++; if (load_inst !== 32'h00000013) begin n_bad++; $display("FAIL first_hold load_inst: got %08h want 00000013", load_inst); end
        n_cmp++; if (en_count - base !== 1) begin n_bad++; $display("FAIL first_pulses count: got %0d want 1", en_count - base); end
    endtask

    task automatic test_full_image();
        int base;
        int ptr = 0;
        int bad_words = 0;
        bit cons;
        rst = 1'b1; step(); rst = 1'b0; step();
        got.delete();
        base = en_count;
        do_start();
        byte_valid = 1'b1;
        for (int c = 0; c < 2000 && (en_count - base) < WORDS; c++) begin
            byte_data = img_byte(ptr);
            cons = byte_ready;
            step();
            if (cons) ptr++;
        end
        n_cmp++; if (en_count - base !== WORDS) begin
            n_bad++; $display("FAIL full_pulses count: got %0d want %0d", en_count - base, WORDS);
        end
        // Cycle M (last strobe): not done yet.
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL full_last done: got %0b want 0", done); end
        for (int w = 0; w < got.size() && w < WORDS; w++) begin
            if (got[w] !== {img_byte(4*w+3), img_byte(4*w+2), img_byte(4*w+1), img_byte(4*w)}) bad_words++;
        end
        n_cmp++; if (bad_words != 0) begin n_bad++; $display("FAIL full_words wrong words: got %0d want 0", bad_words); end
        step();
        // Cycle M+1: image complete.
        n_cmp++; if (done !== 1'b1 || cpu_rst !== 1'b0) begin
            n_bad++; $display("FAIL full_done done/cpu_rst: got %0b/%0b want 1/0", done, cpu_rst);
        end
        n_cmp++; if (word_count !== 9'd256) begin n_bad++; $display("FAIL full_count word_count: got %0d want 256", word_count); end
        repeat (5) step();
        n_cmp++; if (byte_ready !== 1'b0 || en_count - base !== WORDS || ptr !== 4*WORDS || done !== 1'b1) begin
            n_bad++; $display("FAIL full_after ready/pulses/bytes/done: got %0b/%0d/%0d/%0b want 0/%0d/%0d/1",
                              byte_ready, en_count - base, ptr, done, WORDS, 4*WORDS);
        end
        byte_valid = 1'b0;
    endtask

    task automatic test_stall();
        logic [31:0] words [3] = '{32'hDEADBEEF, 32'h00000093, 32'h12345678};
        int base;
        got.delete();
        base = en_count;
        do_start();
        // Restart from DONE clears the count and re-asserts core reset.
        n_cmp++; if (word_count !== 9'd0 || cpu_rst !== 1'b1 || done !== 1'b0) begin
            n_bad++; $display("FAIL restart count/cpu_rst/done: got %0d/%0b/%0b want 0/1/0", word_count, cpu_rst, done);
        end
        for (int i = 0; i < 3; i++) send_word(words[i], 1'b1);
        byte_valid = 1'b0;
        step();
        n_cmp++; if (en_count - base !== 3) begin n_bad++; $display("FAIL stall_pulses count: got %0d want 3", en_count - base); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (got.size() <= i || got[i] !== words[i]) begin
                n_bad++; $display("FAIL stall_word%0d load_inst: got %08h want %08h", i, (got.size() > i) ? got[i] : 32'hx, words[i]);
            end
        end
    endtask

    task automatic test_timeout();
        int base = en_count;
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        byte_valid = 1'b0;
        repeat (TIMEOUT - 1) step();
        n_cmp++; if (busy !== 1'b1 || error !== 1'b0) begin
            n_bad++; $display("FAIL timeout_early busy/error: got %0b/%0b want 1/0", busy, error);
        end
        step();
        n_cmp++; if (busy !== 1'b0 || error !== 1'b1 || cpu_rst !== 1'b1 || done !== 1'b0) begin
            n_bad++; $display("FAIL timeout_fire busy/error/cpu_rst/done: got %0b/%0b/%0b/%0b want 0/1/1/0", busy, error, cpu_rst, done);
        end
        repeat (3) step();
        n_cmp++; if (error !== 1'b1 || en_count !== base) begin
            n_bad++; $display("FAIL timeout_sticky error/pulses: got %0b/%0d want 1/0", error, en_count - base);
        end
        got.delete();
        do_start();
        n_cmp++; if (error !== 1'b0 || word_count !== 9'd0 || byte_ready !== 1'b1) begin
            n_bad++; $display("FAIL timeout_restart error/count/ready: got %0b/%0d/%0b want 0/0/1", error, word_count, byte_ready);
        end
        send_word(32'hCAFEF00D, 1'b0);
        byte_valid = 1'b0;
        step();
        n_cmp++; if (got.size() != 1 || got[0] !== 32'hCAFEF00D || word_count !== 9'd1) begin
            n_bad++; $display("FAIL timeout_reload pulses/word/count: got %0d/%08h/%0d want 1/cafef00d/1",
                              got.size(), (got.size() > 0) ? got[0] : 32'hx, word_count);
        end
    endtask

    task automatic test_load_done();
        int base;
        rst = 1'b1; step(); rst = 1'b0; step();
        base = en_count;
        do_start();
        for (int w = 0; w < 10; w++) send_word(32'h01000000 * w + 32'h13, 1'b0);
        send_byte(8'h37, 1'b0);
        send_byte(8'h0F, 1'b0);
        byte_valid = 1'b0;
        load_done  = 1'b1;
        step();
        load_done  = 1'b0;
        n_cmp++; if (done !== 1'b1 || cpu_rst !== 1'b0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL ldone_state done/cpu_rst/busy: got %0b/%0b/%0b want 1/0/0", done, cpu_rst, busy);
        end
        n_cmp++; if (word_count !== 9'd10) begin n_bad++; $display("FAIL ldone_count word_count: got %0d want 10", word_count); end
        byte_valid = 1'b1;
        repeat (5) step();
        byte_valid = 1'b0;
        n_cmp++; if (en_count - base !== 10 || byte_ready !== 1'b0) begin
            n_bad++; $display("FAIL ldone_pulses count/ready: got %0d/%0b want 10/0", en_count - base, byte_ready);
        end
    endtask

    task automatic test_reset_mid();
        int base = en_count;
        do_start();
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        byte_data  = 8'h44;
        byte_valid = 1'b1;
        rst        = 1'b1;
        #1;
        n_cmp++; if (load_en !== 1'b0 || load_inst !== 32'h0 || byte_ready !== 1'b0 || cpu_rst !== 1'b1 ||
                     busy !== 1'b0 || done !== 1'b0 || error !== 1'b0 || word_count !== 9'd0) begin
            n_bad++; $display("FAIL midrst outputs en/inst/ready/cpu_rst/busy/done/err/cnt: got %0b/%08h/%0b/%0b/%0b/%0b/%0b/%0d want 0/0/0/1/0/0/0/0",
                              load_en, load_inst, byte_ready, cpu_rst, busy, done, error, word_count);
        end
        repeat (3) step();
        rst = 1'b0;
        repeat (3) step();
        byte_valid = 1'b0;
        n_cmp++; if (en_count !== base || busy !== 1'b0 || cpu_rst !== 1'b1) begin
            n_bad++; $display("FAIL midrst_after pulses/busy/cpu_rst: got %0d/%0b/%0b want 0/0/1", en_count - base, busy, cpu_rst);
        end
    endtask

    initial begin
        test_reset();
        test_first_word();
        test_full_image();
        test_stall();
        test_timeout();
        test_load_done();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
# prog_loader

Boot-time program loader that sits directly upstream of the instruction memory. It accepts a byte stream from a host link, assembles little-endian 32-bit words and writes them one at a time into instruction memory via `load_en`/`load_inst`. It holds the core in reset until the image is complete, as signalled by the memory's `load_done` or the loader's own word count.

## Interface
- `WORDS`, 256: number of words in a full image; the load ends after this many writes.
- `TIMEOUT`, 1024: idle cycles allowed between bytes of a partially assembled word before aborting.
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a load; sampled only in IDLE and DONE.
- `byte_valid`  in  1  host byte present.
- `byte_data`  in  8  host byte.
- `byte_ready`  out  1  loader accepts a byte this cycle.
- `load_done`  in  1  instruction memory reports that the image is fully written.
- `load_en`  out  1  one-cycle write strobe to instruction memory.
- `load_inst`  out  32  assembled word; valid while `load_en`=1.
- `cpu_rst`  out  1  core reset hold; high until DONE.
- `busy`  out  1  high in COLLECT and WRITE.
- `done`  out  1  high in DONE.
- `error`  out  1  sticky timeout flag; cleared by `start` or reset.
- `word_count`  out  9  words written in the current load.

## Operation
- States: IDLE, COLLECT, WRITE, DONE.
- IDLE:
  - `start`=1 -> COLLECT.
  - Clears `word_count`, the byte index and `error`.
- COLLECT:
  - `byte_ready`=1.
  - A byte is accepted when `byte_valid` and `byte_ready` are both high.
  - Byte index 0..3 places the byte in bits [7:0], [15:8], [23:16], [31:24] of the assembly register.
  - Acceptance at index 3 -> WRITE, with the index wrapping to 0.
- WRITE:
  - `load_en`=1 for exactly one cycle; `load_inst` = assembled word; `byte_ready`=0.
  - `word_count` increments.
  - Next state is DONE if the incremented count equals `WORDS`, else COLLECT.
- DONE:
  - `cpu_rst`=0, `done`=1, `byte_ready`=0.
  - `start`=1 -> COLLECT, applying the same clears as IDLE; `cpu_rst` returns to 1 in that cycle.
- `load_done`=1 in COLLECT -> DONE next cycle.
  - Any partial word is discarded and no write is issued.
  - `load_done` in WRITE: the write completes, then the next state is DONE.
- Timeout:
  - In COLLECT with byte index ≠ 0, a counter increments each cycle without an accepted byte.
  - It resets on every accepted byte.
  - Reaching `TIMEOUT` -> IDLE, sets `error`=1, discards the partial word; `cpu_rst` stays 1.
- `start` is ignored in COLLECT and WRITE.
- `word_count` saturates at `WORDS`; it never wraps.

## Timing
- Reset values:
  - `load_en`=0, `load_inst`=0, `byte_ready`=0, `cpu_rst`=1.
  - `busy`=0, `done`=0, `error`=0, `word_count`=0; state IDLE.
- Reset mid-load aborts immediately: no `load_en` pulse follows, and the memory contents are left to the memory's own reset.
- All outputs are registered or decoded from the state register only; there is no combinational path from inputs to outputs.
- Latency:
  - 4th byte accepted in cycle N -> `load_en`=1 in cycle N+1.
  - `byte_ready` is back to 1 in cycle N+2.
  - Minimum 5 cycles per word.
- `load_inst` holds its value after the strobe until the next WRITE.
- Last write in cycle M -> `done`=1 and `cpu_rst`=0 in cycle M+1.
- `byte_valid` may be held high continuously; a byte offered while `byte_ready`=0 is not consumed.

## Test plan
- Reset, then `start`; stream bytes 0x13,0x00,0x00,0x00 back-to-back -> one `load_en` pulse with `load_inst`=0x00000013, 4 cycles after `start`+1; `word_count`=1.
- Full image of `WORDS`=256 words, `byte_valid` always high -> 256 pulses; `done`=1 and `cpu_rst`=0 one cycle after the last pulse; further bytes not accepted.
- Deassert `byte_valid` randomly during a load -> words assemble unchanged; no spurious `load_en`.
- Send 2 bytes, then idle for `TIMEOUT` cycles -> `error`=1, state IDLE, no write; a following `start` clears `error`, and a new word loads correctly.
- Assert `load_done` after 10 words while 2 bytes are pending -> DONE next cycle, `word_count`=10, no 11th `load_en`.
- Assert `rst` in the cycle after the 3rd byte -> all outputs at reset values, no `load_en` afterwards.
